// File: rtl/ifu_pkg.sv
// ifu_pkg: default parameters and FIFO entry layout shared by the fetch unit
package ifu_pkg;
    localparam int IFU_DATA_W = 16;
    localparam int IFU_ADDR_W = 8;
    localparam int IFU_DEPTH  = 4;
    typedef struct packed {
        logic [IFU_DATA_W-1:0] instr;
        logic [IFU_ADDR_W-1:0] pc;
    } ifu_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush overriding push/pop, head exposed combinationally
module ifu_fifo import ifu_pkg::*; #(
    parameter int W     = IFU_DATA_W + IFU_ADDR_W,
    parameter int DEPTH = IFU_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             data_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [W-1:0]             head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential fetch into a prefetch FIFO with redirect flush
// IFU_PERF_CNT_EN adds the fetch_count handshake counter
module ifu_prefetch import ifu_pkg::*; #(
    parameter int DATA_W   = IFU_DATA_W,
    parameter int ADDR_W   = IFU_ADDR_W,
    parameter int DEPTH    = IFU_DEPTH,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W-1:0]        pc_q, inflight_pc_q;
    logic                     inflight_q;
    logic [CW-1:0]            count;
    logic [DATA_W+ADDR_W-1:0] head;
    logic                     pop, push;
    // counting the in-flight slot guarantees a return always finds room
    assign imem_req    = rst && !redirect_valid && (count + CW'(inflight_q) < CW'(DEPTH));
    assign imem_addr   = pc_q;
    assign instr_valid = count != '0;
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight_q && !redirect_valid;
    assign {instr, instr_pc} = head;
    ifu_fifo #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ({imem_rdata, inflight_pc_q}),
        .count_o (count),
        .head_o  (head)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (imem_req) begin
                pc_q          <= pc_q + ADDR_W'(PC_STEP);
                inflight_pc_q <= pc_q;
            end
        end
    end
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    always_ff @(posedge clk) begin
        if (!rst) fetch_count_q <= '0;
        else if (pop) fetch_count_q <= fetch_count_q + 32'd1;
    end
    assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: randomized and directed checks of ifu_prefetch against an in-order PC stream model
module tb_ifu_prefetch;
    logic        clk, rst, redirect_valid, instr_ready;
    logic [7:0]  redirect_pc;
    logic        imem_req, imem_req_w, instr_valid, instr_valid_w;
    logic [7:0]  imem_addr, imem_addr_w, instr_pc, instr_pc_w;
    logic [15:0] imem_rdata, imem_rdata_w, instr, instr_w;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count, fetch_count_w;
`endif
    int total, bad;

    ifu_prefetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IFU_PERF_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );
    ifu_prefetch #(.RESET_PC(8'hFE)) dut_w (
        .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid_w),
        .instr_ready(instr_ready), .instr(instr_w), .instr_pc(instr_pc_w)
`ifdef IFU_PERF_CNT_EN
        , .fetch_count(fetch_count_w)
`endif
    );

    always #5 clk = ~clk;
    // instruction memory: word at address a is 16'h1000 + a, one cycle latency
    always @(posedge clk) begin
        imem_rdata   <= 16'h1000 + {8'h00, imem_addr};
        imem_rdata_w <= 16'h1000 + {8'h00, imem_addr_w};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // leaves the bench at the sampling point of cycle R
    task automatic start(input logic rdy);
        step();
        rst = 0;
        redirect_valid = 0;
        instr_ready = rdy;
        step();
        step();
        rst = 1;
        samp();
    endtask

    task automatic test_reset();
        step();
        rst = 0;
        instr_ready = 0;
        redirect_valid = 0;
        step();
        step();
        samp();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 16'h0 || instr_pc !== 8'h0) begin bad++; $display("FAIL reset_head: got %h/%h want 0000/00", instr, instr_pc); end
        total++; if (imem_addr_w !== 8'hFE) begin bad++; $display("FAIL reset_addr_w: got %h want fe", imem_addr_w); end
`ifdef IFU_PERF_CNT_EN
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_count); end
`endif
    endtask

    task automatic test_free_flow();
        start(1);
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL ff_first_req: got %b/%h want 1/00", imem_req, imem_addr); end
        step(); samp();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_r1_valid: got %b want 0", instr_valid); end
        for (int k = 0; k < 12; k++) begin
            logic [7:0] e;
            e = 8'(k);
            step(); samp();
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== e || instr !== {8'h10, e}) begin
                bad++; $display("FAIL ff_stream%0d: got v=%b %h/%h want v=1 %h/%h", k, instr_valid, instr, instr_pc, {8'h10, e}, e);
            end
        end
    endtask

    task automatic test_wrap();
        start(1);
        step(); samp();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] e;
            e = 8'(254 + k);
            step(); samp();
            total++;
            if (instr_valid_w !== 1'b1 || instr_pc_w !== e || instr_w !== {8'h10, e}) begin
                bad++; $display("FAIL wrap%0d: got v=%b %h/%h want v=1 %h/%h", k, instr_valid_w, instr_w, instr_pc_w, {8'h10, e}, e);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] e;
        start(0);
        n = int'(imem_req);
        for (int i = 1; i < 10; i++) begin
            step(); samp();
            n += int'(imem_req);
        end
        total++; if (n != 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", n); end
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL bp_stalled: got req=%b v=%b want req=0 v=1", imem_req, instr_valid); end
        e = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            instr_ready = 1;
            samp();
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== e || instr !== {8'h10, e}) begin bad++; $display("FAIL bp_order: got %h/%h want %h/%h", instr, instr_pc, {8'h10, e}, e); end
                e++;
            end
        end
        total++; if (e != 8'd16) begin bad++; $display("FAIL bp_throughput: got %0d want 16", e); end
    endtask

    task automatic test_redirect();
        start(0);
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1;
        redirect_pc = 8'h40;
        samp();
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL rd_T: got req=%b v=%b want req=0 v=1", imem_req, instr_valid); end
        step();
        redirect_valid = 0;
        samp();
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin bad++; $display("FAIL rd_T1: got req=%b a=%h v=%b want 1/40/0", imem_req, imem_addr, instr_valid); end
        step(); samp();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_T2_valid: got %b want 0", instr_valid); end
        step();
        instr_ready = 1;
        samp();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || instr !== 16'h1040) begin bad++; $display("FAIL rd_T3: got v=%b %h/%h want 1 1040/40", instr_valid, instr, instr_pc); end
        step(); samp();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h41 || instr !== 16'h1041) begin bad++; $display("FAIL rd_T4: got v=%b %h/%h want 1 1041/41", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_mid_reset();
        start(0);
        for (int i = 0; i < 9; i++) step();
        rst = 0;
        samp();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mr_req_in_reset: got %b want 0", imem_req); end
        step();
        rst = 1;
        instr_ready = 1;
        samp();
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL mr_R: got v=%b req=%b a=%h want 0/1/00", instr_valid, imem_req, imem_addr); end
        step(); samp();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mr_R1: got %b want 0", instr_valid); end
        step(); samp();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 16'h1000) begin bad++; $display("FAIL mr_R2: got v=%b %h/%h want 1 1000/00", instr_valid, instr, instr_pc); end
    endtask

    // expected stream: consecutive PCs, restarting at the target after each redirect
    task automatic test_random();
        logic [7:0] e;
        logic prev_redir;
        int hs;
        start(1);
        e = 0;
        hs = 0;
        prev_redir = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            instr_ready = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc = 8'($urandom);
            samp();
            if (prev_redir) begin
                total++;
                if (instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_post_redirect: got v=%b want 0", instr_valid); end
            end
            if (instr_valid && instr_ready) begin
                total++;
                if (instr_pc !== e || instr !== {8'h10, e}) begin bad++; $display("FAIL rnd_stream: got %h/%h want %h/%h", instr, instr_pc, {8'h10, e}, e); end
                e++;
                hs++;
            end
            if (redirect_valid) e = redirect_pc;
            prev_redir = redirect_valid;
        end
        total++; if (hs < 100) begin bad++; $display("FAIL rnd_progress: got %0d handshakes want >=100", hs); end
        step();
        redirect_valid = 0;
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf();
        int hs;
        start(1);
        hs = 0;
        for (int i = 0; i < 300 && hs < 20; i++) begin
            step();
            instr_ready = $urandom_range(0, 1) != 0;
            redirect_valid = i == 8;
            redirect_pc = 8'h80;
            samp();
            if (instr_valid && instr_ready) hs++;
        end
        step();
        instr_ready = 0;
        redirect_valid = 0;
        samp();
        total++; if (hs != 20) begin bad++; $display("FAIL perf_bound: got %0d handshakes want 20", hs); end
        total++; if (fetch_count !== 32'd20) begin bad++; $display("FAIL perf_count: got %0d want 20", fetch_count); end
        step();
        rst = 0;
        step();
        samp();
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL perf_reset: got %0d want 0", fetch_count); end
        rst = 1;
    endtask
`endif

    initial begin
        clk = 0;
        rst = 0;
        redirect_valid = 0;
        redirect_pc = 0;
        instr_ready = 0;
        total = 0;
        bad = 0;
        test_reset();
        test_free_flow();
        test_wrap();
        test_backpressure();
        test_redirect();
        test_mid_reset();
        test_random();
`ifdef IFU_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
